// File: rtl/spi_cmd_frame_tx.sv
// rtl/spi_cmd_frame_tx.sv - SPI mode-0 master sending a 32-bit control word as five tagged 16-bit frames
module spi_cmd_frame_tx #(
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] cmd_data,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    output logic        busy,
    output logic        sclk,
    output logic        cs_n,
    output logic        mosi,
    input  logic        miso,
    output logic [15:0] status_data,
    output logic        status_valid
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t           state_q;
    logic [24:0]      cmd_q;          // only the bits that reach the wire: {cmd[31:27], cmd[19:0]}
    logic [15:0]      frame_q;
    logic [15:0]      cap_q;
    logic [2:0]       frame_idx_q;
    logic [3:0]       bit_cnt_q;
    logic [DIV_W-1:0] div_cnt_q;
    logic [GAP_W-1:0] gap_cnt_q;
    logic             sclk_q;
    logic             cs_n_q;
    logic             mosi_q;
    logic             cmd_ready_q;
    logic             busy_q;
    logic [15:0]      status_data_q;
    logic             status_valid_q;

    logic [24:0]      cmd_pack_d;
    logic [15:0]      first_frame_d;
    logic [15:0]      next_frame_d;

    // cmd_data[26:20] has no frame slot; reduced here so the dropped bits are visibly intentional
    logic unused_cmd_bits;
    assign unused_cmd_bits = ^cmd_data[26:20];

    // Packed word layout: c[24]=cmd[31], c[23:22]=cmd[30:29], c[21:20]=cmd[28:27], c[19:0]=cmd[19:0]
    function automatic logic [15:0] encode_frame(input logic [2:0] idx, input logic [24:0] c);
        logic [15:0] f;
        case (idx)
            3'd0:    f = {4'd2, c[11:0]};
            3'd1:    f = {4'd3, 4'd0, c[19:12]};
            3'd2:    f = {4'd4, 10'd0, c[21:20]};
            3'd3:    f = {4'd5, 10'd0, c[23:22]};
            default: f = {4'd6, 11'd0, c[24]};
        endcase
        return f;
    endfunction

    // Frame words for the accepting edge (from the live input) and for the next frame (from the latch)
    always_comb begin
        cmd_pack_d    = {cmd_data[31:27], cmd_data[19:0]};
        first_frame_d = encode_frame(3'd0, cmd_pack_d);
        next_frame_d  = encode_frame(frame_idx_q + 3'd1, cmd_q);
    end

    // Control FSM; every SPI pin and handshake output is a register so the link sees no glitches
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            cmd_q          <= '0;
            frame_q        <= '0;
            cap_q          <= '0;
            frame_idx_q    <= '0;
            bit_cnt_q      <= '0;
            div_cnt_q      <= '0;
            gap_cnt_q      <= '0;
            sclk_q         <= 1'b0;
            cs_n_q         <= 1'b1;
            mosi_q         <= 1'b0;
            cmd_ready_q    <= 1'b0;
            busy_q         <= 1'b0;
            status_data_q  <= '0;
            status_valid_q <= 1'b0;
        end else begin
            status_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    cmd_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                    cs_n_q      <= 1'b1;
                    sclk_q      <= 1'b0;
                    mosi_q      <= 1'b0;
                    if (cmd_valid && cmd_ready_q) begin
                        cmd_q       <= cmd_pack_d;
                        frame_q     <= first_frame_d;
                        frame_idx_q <= 3'd0;
                        bit_cnt_q   <= 4'd15;
                        div_cnt_q   <= '0;
                        cs_n_q      <= 1'b0;
                        mosi_q      <= first_frame_d[15];
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (div_cnt_q == DIV_LAST) begin
                        div_cnt_q <= '0;
                        if (!sclk_q) begin
                            // rising SCLK edge: receiver has had a full low phase to drive MISO
                            sclk_q <= 1'b1;
                            cap_q  <= {cap_q[14:0], miso};
                        end else if (bit_cnt_q == 4'd0) begin
                            sclk_q         <= 1'b0;
                            cs_n_q         <= 1'b1;
                            mosi_q         <= 1'b0;
                            status_data_q  <= cap_q;
                            status_valid_q <= 1'b1;
                            gap_cnt_q      <= '0;
                            state_q        <= ST_GAP;
                        end else begin
                            sclk_q    <= 1'b0;
                            bit_cnt_q <= bit_cnt_q - 4'd1;
                            mosi_q    <= frame_q[bit_cnt_q - 4'd1];
                        end
                    end else begin
                        div_cnt_q <= div_cnt_q + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_q == GAP_LAST) begin
                        if (frame_idx_q == 3'd4) begin
                            frame_idx_q <= 3'd0;
                            cmd_ready_q <= 1'b1;
                            busy_q      <= 1'b0;
                            state_q     <= ST_IDLE;
                        end else begin
                            frame_idx_q <= frame_idx_q + 3'd1;
                            frame_q     <= next_frame_d;
                            mosi_q      <= next_frame_d[15];
                            cs_n_q      <= 1'b0;
                            bit_cnt_q   <= 4'd15;
                            div_cnt_q   <= '0;
                            state_q     <= ST_SHIFT;
                        end
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready    = cmd_ready_q;
    assign busy         = busy_q;
    assign sclk         = sclk_q;
    assign cs_n         = cs_n_q;
    assign mosi         = mosi_q;
    assign status_data  = status_data_q;
    assign status_valid = status_valid_q;

endmodule
